spi_txn_sequencer: RTL and testbench

// - SPI master-side transaction sequencer for the SPI wrapper (SPI slave + 256x8 RAM).
// - Converts one host request (WRITE addr,data / READ addr) into the two 11-bit SPI frames:

---
 rtl/spi_txn_sequencer.sv | 256 +++++++++++++++++++++++++
 tb/tb_spi_txn_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_txn_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : spi_txn_sequencer
// Description : SPI master-side transaction sequencer. Turns one host
//               WRITE/READ request into an address frame and a data frame
//               (11 bits each) on SS_n/MOSI, one bit per clk, and captures
//               MISO for reads.
//               Optional feature macro: SPI_ADDR_SKIP_EN (skip the address
//               frame when addr and kind repeat the last completed request).
// Revision    : 1.0 - initial release
// ============================================================================
module spi_txn_sequencer #(
    parameter int ADDR_W        = 8,
    parameter int DATA_W        = 8,
    parameter int RD_TURNAROUND = 2,
    parameter int IDLE_GAP      = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              SS_n,
    output logic              MOSI,
    input  logic              MISO
);

    localparam int c_PAY_W   = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int c_FRAME_W = c_PAY_W + 3;
    localparam int c_M1      = (c_FRAME_W > DATA_W) ? c_FRAME_W : DATA_W;
    localparam int c_M2      = (RD_TURNAROUND > IDLE_GAP) ? RD_TURNAROUND : IDLE_GAP;
    localparam int c_CNT_MAX = (c_M1 > c_M2) ? c_M1 : c_M2;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_SHIFT_LAST = c_CNT_W'(c_FRAME_W - 1);
    localparam logic [c_CNT_W-1:0] c_TURN_LAST  = c_CNT_W'((RD_TURNAROUND > 0) ? RD_TURNAROUND - 1 : 0);
    localparam logic [c_CNT_W-1:0] c_CAPT_LAST  = c_CNT_W'(DATA_W - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST   = c_CNT_W'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEL   = 3'd1,
        S_SHIFT = 3'd2,
        S_TAIL  = 3'd3,
        S_TURN  = 3'd4,
        S_CAPT  = 3'd5,
        S_GAP   = 3'd6
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic                 r_phase;        // 0 = address frame, 1 = data frame
    logic                 w_phase_nxt;
    logic                 w_accept;
    logic                 w_skip;
    logic                 w_rsp_fire;
    logic [c_FRAME_W-1:0] r_frame;        // remaining bits, current bit at MSB
    logic [c_FRAME_W-1:0] w_frame_nxt;
    logic [c_FRAME_W-1:0] w_frame;
    logic [1:0]           w_cmd;
    logic [c_PAY_W-1:0]   w_payload;
    logic                 w_mosi_nxt;
    logic [DATA_W-2:0]    r_cap;
    logic [DATA_W-1:0]    w_cap_nxt;
    logic                 r_wr;
    logic [ADDR_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_wdata;
    logic                 r_ss_n;
    logic                 r_mosi;
    logic                 r_ready;
    logic                 r_busy;
    logic                 r_rsp_valid;
    logic [DATA_W-1:0]    r_rsp_data;

    assign w_cap_nxt = {r_cap, MISO};

    // Frame image for the current phase: {cmd[1], cmd[1:0], payload}
    always_comb begin
        w_cmd = {~r_wr, r_phase};
        if (!r_phase) begin
            w_payload = c_PAY_W'(r_addr);
        end else if (r_wr) begin
            w_payload = c_PAY_W'(r_wdata);
        end else begin
            w_payload = '0;
        end
        w_frame = {w_cmd[1], w_cmd, w_payload};
    end

    // Next-state, counter, phase and serial-data decode
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_phase_nxt = r_phase;
        w_accept    = 1'b0;
        w_rsp_fire  = 1'b0;
        w_mosi_nxt  = 1'b0;
        w_frame_nxt = r_frame;
        case (r_state)
            S_IDLE: begin
                w_phase_nxt = 1'b0;
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_SEL;
                    w_cnt_nxt   = '0;
                    w_phase_nxt = w_skip;
                end
            end
            S_SEL: begin
                w_state_nxt = S_SHIFT;
                w_cnt_nxt   = '0;
                w_mosi_nxt  = w_frame[c_FRAME_W-1];
                w_frame_nxt = w_frame << 1;
            end
            S_SHIFT: begin
                if (r_cnt == c_SHIFT_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_phase && !r_wr) begin
                        w_state_nxt = (RD_TURNAROUND > 0) ? S_TURN : S_CAPT;
                    end else begin
                        w_state_nxt = S_TAIL;
                    end
                end else begin
                    w_cnt_nxt   = r_cnt + c_CNT_ONE;
                    w_mosi_nxt  = r_frame[c_FRAME_W-1];
                    w_frame_nxt = r_frame << 1;
                end
            end
            S_TAIL: begin
                w_state_nxt = S_GAP;
                w_cnt_nxt   = '0;
            end
            S_TURN: begin
                if (r_cnt == c_TURN_LAST) begin
                    w_state_nxt = S_CAPT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            S_CAPT: begin
                if (r_cnt == c_CAPT_LAST) begin
                    w_state_nxt = S_GAP;
                    w_cnt_nxt   = '0;
                    w_rsp_fire  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            S_GAP: begin
                if (r_cnt == c_GAP_LAST) begin
                    w_cnt_nxt = '0;
                    if (!r_phase) begin
                        w_phase_nxt = 1'b1;
                        w_state_nxt = S_SEL;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register and registered outputs; SS_n low in every in-frame state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_phase     <= 1'b0;
            r_frame     <= '0;
            r_cap       <= '0;
            r_ss_n      <= 1'b1;
            r_mosi      <= 1'b0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_phase     <= w_phase_nxt;
            r_frame     <= w_frame_nxt;
            r_ss_n      <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_GAP);
            r_mosi      <= w_mosi_nxt;
            r_ready     <= (w_state_nxt == S_IDLE);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_rsp_valid <= w_rsp_fire;
            if (r_state == S_CAPT) begin
                r_cap <= w_cap_nxt[DATA_W-2:0];
            end
            if (w_rsp_fire) begin
                r_rsp_data <= w_cap_nxt;
            end
        end
    end

    // Request capture on handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_wr    <= req_wr;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
        end
    end

`ifdef SPI_ADDR_SKIP_EN
    logic              r_last_vld;
    logic              r_last_wr;
    logic [ADDR_W-1:0] r_last_addr;
    logic              w_done;

    assign w_done = (r_state == S_GAP) && (r_cnt == c_GAP_LAST) && r_phase;
    assign w_skip = r_last_vld && (r_last_wr == req_wr) && (r_last_addr == req_addr);

    // Remember the last completed request for address-frame elision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_vld  <= 1'b0;
            r_last_wr   <= 1'b0;
            r_last_addr <= '0;
        end else if (w_done) begin
            r_last_vld  <= 1'b1;
            r_last_wr   <= r_wr;
            r_last_addr <= r_addr;
        end
    end
`else
    assign w_skip = 1'b0;
`endif

    assign req_ready = r_ready;
    assign busy      = r_busy;
    assign SS_n      = r_ss_n;
    assign MOSI      = r_mosi;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_spi_txn_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_txn_sequencer
// Description : Directed self-checking bench for spi_txn_sequencer with a
//               behavioural SPI slave + 256x8 RAM model on the bus.
//               Honours SPI_ADDR_SKIP_EN for the expected frame counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_txn_sequencer;

    localparam int TB_RT   = 2;
    localparam int TB_GAP  = 1;
    localparam int CAP0    = 12 + TB_RT;      // frame cycle of first MISO bit
    localparam int LEN_STD = 13;
    localparam int LEN_RD  = 12 + TB_RT + 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_wr;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;
    logic       SS_n;
    logic       MOSI;
    logic       miso;

    int n_tests = 0;
    int n_fail  = 0;

    spi_txn_sequencer #(
        .ADDR_W(8), .DATA_W(8), .RD_TURNAROUND(TB_RT), .IDLE_GAP(TB_GAP)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .SS_n(SS_n), .MOSI(MOSI), .MISO(miso)
    );

    always #5 clk = ~clk;

    // ---------------- slave + RAM model ----------------
    logic [7:0]  mem [256];
    logic [10:0] frames [$];
    int          lens [$];
    int          gaps [$];
    logic [10:0] shreg;
    logic [7:0]  wr_addr, rd_addr, rd_byte;
    int          idx, gap_cnt, mosi_bad, rsp_cnt, rsp_bad;
    bit          prev_ss = 1'b1;
    bit          have_prev = 1'b0;

    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            rsp_cnt++;
            if (!(SS_n === 1'b1 && prev_ss == 1'b0)) rsp_bad++;
        end
        if (SS_n === 1'b0) begin
            if (prev_ss) begin
                idx = 0;
                shreg = '0;
                if (have_prev) gaps.push_back(gap_cnt);
            end else begin
                idx++;
            end
            if (idx >= 1 && idx <= 11) shreg = {shreg[9:0], MOSI};
            else if (MOSI !== 1'b0) mosi_bad++;
            if (idx >= CAP0 && idx < CAP0 + 8 && shreg[9:8] == 2'b11) begin
                rd_byte = mem[rd_addr];
                miso = rd_byte[CAP0 + 7 - idx];
            end else begin
                miso = 1'b0;
            end
        end else begin
            miso = 1'b0;
            if (!prev_ss) begin
                frames.push_back(shreg);
                lens.push_back(idx + 1);
                case (shreg[9:8])
                    2'b00: wr_addr = shreg[7:0];
                    2'b01: mem[wr_addr] = shreg[7:0];
                    2'b10: rd_addr = shreg[7:0];
                    default: ;
                endcase
                gap_cnt = 1;
                have_prev = 1'b1;
            end else begin
                gap_cnt++;
            end
        end
        prev_ss = SS_n;
    end

    // ---------------- helpers (stimulus only) ----------------
    task automatic clear_log();
        frames.delete(); lens.delete(); gaps.delete();
        have_prev = 1'b0; mosi_bad = 0; rsp_cnt = 0; rsp_bad = 0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((busy !== 1'b0 || SS_n !== 1'b1) && n < 400) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (n >= 400) begin
            n_fail++;
            $display("FAIL %s_timeout: busy=%b still high after %0d clks, required 0", name, busy, n);
        end
        @(negedge clk);
    endtask

    task automatic do_req(input logic wr, input logic [7:0] a, input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0;
        wait_done("req");
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_tests++; if (SS_n !== 1'b1)     begin n_fail++; $display("FAIL rst_ss_n: got %b expected 1", SS_n); end
        n_tests++; if (MOSI !== 1'b0)     begin n_fail++; $display("FAIL rst_mosi: got %b expected 0", MOSI); end
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b expected 1", req_ready); end
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); end
        n_tests++; if (rsp_data !== 8'h00) begin n_fail++; $display("FAIL rst_rsp_data: got %h expected 00", rsp_data); end
        n_tests++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
        @(negedge clk); rst_n = 1'b1;
        // start WRITE A5 and interrupt it at frame cycle C4 (MOSI=1)
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 8'hA5; req_wdata = 8'h3C;
        @(negedge clk);            // C0
        req_valid = 1'b0;
        repeat (4) @(negedge clk); // C4
        n_tests++; if (SS_n !== 1'b0) begin n_fail++; $display("FAIL c4_ss_n: got %b expected 0", SS_n); end
        n_tests++; if (MOSI !== 1'b1) begin n_fail++; $display("FAIL c4_mosi: got %b expected 1", MOSI); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (SS_n !== 1'b1)      begin n_fail++; $display("FAIL async_ss_n: got %b expected 1", SS_n); end
        n_tests++; if (MOSI !== 1'b0)      begin n_fail++; $display("FAIL async_mosi: got %b expected 0", MOSI); end
        n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL async_busy: got %b expected 0", busy); end
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL async_ready: got %b expected 1", req_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        clear_log();
    endtask

    task automatic test_write();
        clear_log();
        do_req(1'b1, 8'hA5, 8'h3C);
        n_tests++; if (frames.size() != 2) begin n_fail++; $display("FAIL wr_nframes: got %0d expected 2", frames.size()); end
        n_tests++; if (frames[0] !== 11'h0A5) begin n_fail++; $display("FAIL wr_frame0: got %h expected 0a5", frames[0]); end
        n_tests++; if (frames[1] !== 11'h13C) begin n_fail++; $display("FAIL wr_frame1: got %h expected 13c", frames[1]); end
        n_tests++; if (lens[0] != LEN_STD || lens[1] != LEN_STD) begin n_fail++; $display("FAIL wr_len: got %0d/%0d expected %0d", lens[0], lens[1], LEN_STD); end
        n_tests++; if (gaps[0] != TB_GAP) begin n_fail++; $display("FAIL wr_gap: got %0d expected %0d", gaps[0], TB_GAP); end
        n_tests++; if (mem[8'hA5] !== 8'h3C) begin n_fail++; $display("FAIL wr_ram: got %h expected 3c", mem[8'hA5]); end
        n_tests++; if (mosi_bad != 0) begin n_fail++; $display("FAIL wr_mosi_idle: got %0d nonzero bits expected 0", mosi_bad); end
        n_tests++; if (rsp_cnt != 0) begin n_fail++; $display("FAIL wr_no_rsp: got %0d pulses expected 0", rsp_cnt); end
    endtask

    task automatic test_read();
        clear_log();
        do_req(1'b0, 8'hA5, 8'hEE);
        n_tests++; if (frames[0] !== 11'h6A5) begin n_fail++; $display("FAIL rd_frame0: got %h expected 6a5", frames[0]); end
        n_tests++; if (frames[1] !== 11'h700) begin n_fail++; $display("FAIL rd_frame1: got %h expected 700", frames[1]); end
        n_tests++; if (lens[0] != LEN_STD) begin n_fail++; $display("FAIL rd_len0: got %0d expected %0d", lens[0], LEN_STD); end
        n_tests++; if (lens[1] != LEN_RD) begin n_fail++; $display("FAIL rd_len1: got %0d expected %0d", lens[1], LEN_RD); end
        n_tests++; if (rsp_cnt != 1) begin n_fail++; $display("FAIL rd_rsp_pulses: got %0d expected 1", rsp_cnt); end
        n_tests++; if (rsp_bad != 0) begin n_fail++; $display("FAIL rd_rsp_align: got %0d misaligned expected 0", rsp_bad); end
        n_tests++; if (rsp_data !== 8'h3C) begin n_fail++; $display("FAIL rd_data: got %h expected 3c", rsp_data); end
        n_tests++; if (mosi_bad != 0) begin n_fail++; $display("FAIL rd_mosi_idle: got %0d expected 0", mosi_bad); end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        clear_log();
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 8'h10; req_wdata = 8'hFF;
        @(negedge clk);
        req_wr = 1'b0; req_wdata = 8'h00;   // READ 10 queued, valid stays high
        while (req_ready !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_busy: got %b expected 0", busy); end
        @(negedge clk);
        n_tests++; if (busy !== 1'b1 || req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_accept: got busy=%b ready=%b expected 1/0", busy, req_ready); end
        req_valid = 1'b0;
        wait_done("b2b");
        n_tests++; if (frames.size() != 4) begin n_fail++; $display("FAIL b2b_nframes: got %0d expected 4", frames.size()); end
        n_tests++; if (frames[0] !== 11'h010 || frames[1] !== 11'h1FF) begin n_fail++; $display("FAIL b2b_wr_frames: got %h %h expected 010 1ff", frames[0], frames[1]); end
        n_tests++; if (frames[2] !== 11'h610 || frames[3] !== 11'h700) begin n_fail++; $display("FAIL b2b_rd_frames: got %h %h expected 610 700", frames[2], frames[3]); end
        // within a request: GAP only; across requests the IDLE accept clk adds one
        n_tests++; if (gaps[0] != TB_GAP || gaps[2] != TB_GAP) begin n_fail++; $display("FAIL b2b_gap_intra: got %0d/%0d expected %0d", gaps[0], gaps[2], TB_GAP); end
        n_tests++; if (gaps[1] != TB_GAP + 1) begin n_fail++; $display("FAIL b2b_gap_inter: got %0d expected %0d", gaps[1], TB_GAP + 1); end
        n_tests++; if (rsp_data !== 8'hFF) begin n_fail++; $display("FAIL b2b_rd_data: got %h expected ff", rsp_data); end
        n_tests++; if (rsp_cnt != 1) begin n_fail++; $display("FAIL b2b_rsp_pulses: got %0d expected 1", rsp_cnt); end
    endtask

    task automatic test_addr_skip();
        int base;
`ifdef SPI_ADDR_SKIP_EN
        int exp_rd2 = 1;
        logic [10:0] exp_rd2_first = 11'h700;
`else
        int exp_rd2 = 2;
        logic [10:0] exp_rd2_first = 11'h622;
`endif
        clear_log();
        do_req(1'b1, 8'h22, 8'h5A);
        base = frames.size();
        do_req(1'b0, 8'h22, 8'h00);
        n_tests++; if (frames.size() - base != 2) begin n_fail++; $display("FAIL skip_rd1_nframes: got %0d expected 2", frames.size() - base); end
        n_tests++; if (frames[base] !== 11'h622) begin n_fail++; $display("FAIL skip_rd1_first: got %h expected 622", frames[base]); end
        n_tests++; if (rsp_data !== 8'h5A) begin n_fail++; $display("FAIL skip_rd1_data: got %h expected 5a", rsp_data); end
        base = frames.size();
        do_req(1'b0, 8'h22, 8'h00);
        n_tests++; if (frames.size() - base != exp_rd2) begin n_fail++; $display("FAIL skip_rd2_nframes: got %0d expected %0d", frames.size() - base, exp_rd2); end
        n_tests++; if (frames[base] !== exp_rd2_first) begin n_fail++; $display("FAIL skip_rd2_first: got %h expected %h", frames[base], exp_rd2_first); end
        n_tests++; if (rsp_data !== 8'h5A) begin n_fail++; $display("FAIL skip_rd2_data: got %h expected 5a", rsp_data); end
        base = frames.size();
        do_req(1'b1, 8'h22, 8'h77);
        n_tests++; if (frames.size() - base != 2) begin n_fail++; $display("FAIL skip_wr_nframes: got %0d expected 2", frames.size() - base); end
        n_tests++; if (frames[base] !== 11'h022) begin n_fail++; $display("FAIL skip_wr_first: got %h expected 022", frames[base]); end
        n_tests++; if (mem[8'h22] !== 8'h77) begin n_fail++; $display("FAIL skip_wr_ram: got %h expected 77", mem[8'h22]); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        miso = 1'b0; wr_addr = '0; rd_addr = '0; rd_byte = '0; shreg = '0;
        idx = 0; gap_cnt = 0; mosi_bad = 0; rsp_cnt = 0; rsp_bad = 0;
        rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_addr_skip();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1);
    end

endmodule
`default_nettype wire
